vga_timing_gen: RTL and testbench

- Upstream raster timing source for every prompt and sprite controller in the VGA path.
- Divides the system clock down to the pixel rate and runs the horizontal and vertical counters.
- Drives the shared hCount/vCount/bright bus that all overlay controllers consume, plus hSync/vSync to the connector.
- Counter origin is the start of the sync pulse, so overlay coordinates (e.g. X0=265, Y0=277) are in this counter space, not in visible-pixel space.

---
 rtl/vga_timing_gen_if.sv | 18 +
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bus shared by the VGA overlay controllers
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       frame_start;

  modport master (
    output pix_en, hCount, vCount, bright, hSync, vSync, frame_start
  );

  modport slave (
    input pix_en, hCount, vCount, bright, hSync, vSync, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel clock divider and horizontal/vertical raster counters
module vga_timing_gen #(
  parameter int CLK_DIV        = 4,
  parameter int H_TOTAL        = 800,
  parameter int H_SYNC         = 96,
  parameter int H_BRIGHT_START = 144,
  parameter int H_BRIGHT_END   = 784,
  parameter int V_TOTAL        = 525,
  parameter int V_SYNC         = 2,
  parameter int V_BRIGHT_START = 35,
  parameter int V_BRIGHT_END   = 515
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  // Divider width; at least one bit so CLK_DIV=2 still has a real counter.
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0]    V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0]    HB_START = 10'(H_BRIGHT_START);
  localparam logic [9:0]    HB_END   = 10'(H_BRIGHT_END);
  localparam logic [9:0]    VB_START = 10'(V_BRIGHT_START);
  localparam logic [9:0]    VB_END   = 10'(V_BRIGHT_END);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          pix_en_q;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          bright_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          frame_start_q;

  // Next-state counters; ">=" on the wrap tests pulls any out-of-range value back to 0.
  always_comb begin
    div_nxt = (div_cnt >= DIV_LAST) ? '0 : div_cnt + DW'(1);
    h_wrap  = (h_cnt >= H_LAST);
    v_wrap  = (v_cnt >= V_LAST);
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (pix_en_q) begin
      h_nxt = h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // State and decoded outputs; decodes use next-state counters so they line up with hCount/vCount.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt       <= '0;
      pix_en_q      <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      bright_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt       <= div_nxt;
      pix_en_q      <= (div_nxt == DIV_LAST);
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hsync_q       <= (h_nxt >= H_SYNC_W);
      vsync_q       <= (v_nxt >= V_SYNC_W);
      bright_q      <= (h_nxt >= HB_START) && (h_nxt < HB_END) &&
                       (v_nxt >= VB_START) && (v_nxt < VB_END);
      frame_start_q <= pix_en_q && h_wrap && v_wrap;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hCount      = h_cnt;
  assign vga.vCount      = v_cnt;
  assign vga.bright      = bright_q;
  assign vga.hSync       = hsync_q;
  assign vga.vSync       = vsync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for the VGA timing generator
module tb_vga_timing_gen;

  localparam int F_PE    = 0;
  localparam int F_H     = 1;
  localparam int F_V     = 2;
  localparam int F_BR    = 3;
  localparam int F_HS    = 4;
  localparam int F_VS    = 5;
  localparam int F_FS    = 6;
  localparam int F_HSLOW = 7;
  localparam int F_FSCNT = 8;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic sel = 1'b0;
  bit   flush = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_a ();
  vga_timing_gen_if bus_b ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (bus_a)
  );

  vga_timing_gen #(
    .CLK_DIV        (2),
    .H_TOTAL        (20),
    .H_SYNC         (3),
    .H_BRIGHT_START (5),
    .H_BRIGHT_END   (17),
    .V_TOTAL        (10),
    .V_SYNC         (2),
    .V_BRIGHT_START (3),
    .V_BRIGHT_END   (8)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (bus_b)
  );

  logic       m_rst, m_pe, m_br, m_hs, m_vs, m_fs;
  logic [9:0] m_h, m_v;

  always_comb begin
    if (sel) begin
      m_rst = rst_b; m_pe = bus_b.pix_en; m_h = bus_b.hCount; m_v = bus_b.vCount;
      m_br = bus_b.bright; m_hs = bus_b.hSync; m_vs = bus_b.vSync; m_fs = bus_b.frame_start;
    end else begin
      m_rst = rst_a; m_pe = bus_a.pix_en; m_h = bus_a.hCount; m_v = bus_a.vCount;
      m_br = bus_a.bright; m_hs = bus_a.hSync; m_vs = bus_a.vSync; m_fs = bus_a.frame_start;
    end
  end

  exp_t q[$];
  int   cyc = 0;
  int   hslow = 0;
  int   fscnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t e;
  int   act;

  function automatic int act_of(input int f);
    case (f)
      F_PE:    return int'(m_pe);
      F_H:     return int'(m_h);
      F_V:     return int'(m_v);
      F_BR:    return int'(m_br);
      F_HS:    return int'(m_hs);
      F_VS:    return int'(m_vs);
      F_FS:    return int'(m_fs);
      F_HSLOW: return hslow;
      F_FSCNT: return fscnt;
      default: return -1;
    endcase
  endfunction

  // Monitor: cycle 0 is the cycle after the last reset edge; pops every expectation due now.
  always @(negedge clk) begin
    if (!m_rst) begin
      cyc = 0; hslow = 0; fscnt = 0;
    end else begin
      cyc++;
    end
    hslow += m_hs ? 0 : 1;
    fscnt += int'(m_fs);
    while (q.size() > 0 && (flush || q[0].cyc <= cyc)) begin
      e = q.pop_front();
      n_total++;
      if (flush) begin
        $display("FAIL %s: timed out at cycle %0d, expected %0d at cycle %0d", e.name, cyc, e.val, e.cyc);
      end else if (e.cyc < cyc) begin
        $display("FAIL %s: cycle %0d skipped (now %0d), expected %0d", e.name, e.cyc, cyc, e.val);
      end else begin
        act = act_of(e.fld);
        if (act == e.val) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at cycle %0d", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic ex(input int c, input int f, input int v, input string n);
    exp_t t;
    t.cyc = c; t.fld = f; t.val = v; t.name = n;
    q.push_back(t);
  endtask

  task automatic reset_state(input string p);
    ex(0, F_PE, 0, {p, "_rst_pix_en"});
    ex(0, F_H,  0, {p, "_rst_hcount"});
    ex(0, F_V,  0, {p, "_rst_vcount"});
    ex(0, F_BR, 0, {p, "_rst_bright"});
    ex(0, F_HS, 0, {p, "_rst_hsync"});
    ex(0, F_VS, 0, {p, "_rst_vsync"});
    ex(0, F_FS, 0, {p, "_rst_frame_start"});
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (q.size() > 0) begin
      flush = 1'b1;
      @(negedge clk); #1;
      flush = 1'b0;
    end
  endtask

  initial begin
    // Default 640x480 timing: divider phase, line length, sync widths.
    repeat (3) @(posedge clk);
    #1;
    reset_state("a");
    ex(2,    F_PE,    0,   "a_pe_c2");
    ex(3,    F_PE,    1,   "a_pe_first");
    ex(3,    F_H,     0,   "a_h_before_step");
    ex(4,    F_PE,    0,   "a_pe_c4");
    ex(4,    F_H,     1,   "a_h_step1");
    ex(7,    F_PE,    1,   "a_pe_second");
    ex(8,    F_H,     2,   "a_h_step2");
    ex(383,  F_H,     95,  "a_h95");
    ex(383,  F_HS,    0,   "a_hsync_end_low");
    ex(384,  F_H,     96,  "a_h96");
    ex(384,  F_HS,    1,   "a_hsync_rise");
    ex(3199, F_H,     799, "a_h_last");
    ex(3199, F_V,     0,   "a_v_line0");
    ex(3199, F_HSLOW, 384, "a_hsync_low_width");
    ex(3200, F_H,     0,   "a_h_wrap");
    ex(3200, F_V,     1,   "a_v_inc");
    ex(3200, F_HS,    0,   "a_hsync_fall");
    ex(6399, F_V,     1,   "a_v1_end");
    ex(6399, F_VS,    0,   "a_vsync_low");
    ex(6400, F_V,     2,   "a_v2");
    ex(6400, F_VS,    1,   "a_vsync_rise");
    ex(6400, F_FSCNT, 0,   "a_no_frame_start");
    @(negedge clk); #1 rst_a = 1'b1;
    drain(7000);

    // Small raster (2 clk/pixel, 20x10): bright window, frame wrap, frame_start.
    rst_a = 1'b0;
    sel = 1'b1;
    @(posedge clk); #1;
    reset_state("b");
    ex(1,    F_PE,    1,  "b_pe_first");
    ex(2,    F_PE,    0,  "b_pe_c2");
    ex(2,    F_H,     1,  "b_h_step1");
    ex(3,    F_PE,    1,  "b_pe_second");
    ex(39,   F_H,     19, "b_h_last");
    ex(39,   F_HSLOW, 6,  "b_hsync_low_width");
    ex(40,   F_H,     0,  "b_h_wrap");
    ex(40,   F_V,     1,  "b_v_inc");
    ex(79,   F_VS,    0,  "b_vsync_low");
    ex(80,   F_V,     2,  "b_v2");
    ex(80,   F_VS,    1,  "b_vsync_rise");
    ex(90,   F_BR,    0,  "b_bright_v_before");
    ex(129,  F_BR,    0,  "b_bright_h4");
    ex(130,  F_H,     5,  "b_h5");
    ex(130,  F_V,     3,  "b_v3");
    ex(130,  F_BR,    1,  "b_bright_rise");
    ex(153,  F_BR,    1,  "b_bright_h16");
    ex(154,  F_H,     17, "b_h17");
    ex(154,  F_BR,    0,  "b_bright_fall");
    ex(290,  F_BR,    1,  "b_bright_last_line");
    ex(330,  F_BR,    0,  "b_bright_v_after");
    ex(399,  F_H,     19, "b_h_frame_end");
    ex(399,  F_V,     9,  "b_v_frame_end");
    ex(399,  F_FS,    0,  "b_fs_before_wrap");
    ex(399,  F_FSCNT, 0,  "b_no_fs_after_reset");
    ex(400,  F_H,     0,  "b_h_frame_wrap");
    ex(400,  F_V,     0,  "b_v_frame_wrap");
    ex(400,  F_FS,    1,  "b_fs_pulse");
    ex(401,  F_FS,    0,  "b_fs_one_clk");
    ex(800,  F_FS,    1,  "b_fs_second");
    ex(801,  F_FSCNT, 2,  "b_fs_count");
    ex(1061, F_H,     10, "b_pre_reset_h");
    ex(1061, F_V,     6,  "b_pre_reset_v");
    @(negedge clk); #1 rst_b = 1'b1;
    drain(1200);

    // Mid-frame reset with the divider mid-count, then the start-up sequence again.
    rst_b = 1'b0;
    @(posedge clk); #1;
    reset_state("r");
    ex(1,  F_PE,    1, "r_pe_first");
    ex(2,  F_PE,    0, "r_pe_c2");
    ex(2,  F_H,     1, "r_h_step1");
    ex(3,  F_PE,    1, "r_pe_second");
    ex(5,  F_FSCNT, 0, "r_no_fs");
    ex(40, F_H,     0, "r_h_wrap");
    ex(40, F_V,     1, "r_v_inc");
    @(negedge clk); #1 rst_b = 1'b1;
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
